// File: rtl/pipelined_csel_adder.sv
// Two-stage pipelined carry-select adder/subtractor with a valid/ready stream handshake.
// Stage 1 registers per-block ripple sums for both carry-ins; stage 2 resolves the select chain.
module pipelined_csel_adder #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NBLK = WIDTH / BLOCK;

   function automatic logic [BLOCK:0] blk_add(input logic [BLOCK-1:0] x,
                                              input logic [BLOCK-1:0] y,
                                              input logic             c);
      blk_add = {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, c};
   endfunction

   logic                       s1_adv, s2_adv, load_p1, load_p2;
   logic                       vld_p1, vld_p2;
   logic [WIDTH-1:0]           beff;
   logic                       ceff;
   logic [NBLK-1:0][BLOCK-1:0] sum0_c, sum1_c;
   logic [NBLK-1:0]            c0_c, c1_c;
   logic [BLOCK:0]             r0, r1;
   logic [NBLK-1:0][BLOCK-1:0] sum0_p1, sum1_p1;
   logic [NBLK-1:0]            c0_p1, c1_p1;
   logic                       sa_p1, sb_p1;
   logic [WIDTH-1:0]           sum_c;
   logic                       carry_c, ovf_c;
   logic [WIDTH-1:0]           sum_p2;
   logic                       cout_p2, ovf_p2;

   assign s2_adv   = !vld_p2 || out_ready;
   assign s1_adv   = !vld_p1 || s2_adv;
   assign in_ready = s1_adv;
   assign load_p1  = in_valid && s1_adv;
   assign load_p2  = vld_p1 && s2_adv;

   // Stage 1: block 0 carries the true carry-in in both slots, so the
   // stage-2 chain can start from carry 0 and treat every block uniformly.
   always_comb begin
      beff   = sub ? ~b : b;
      ceff   = sub | cin;
      sum0_c = '0;
      sum1_c = '0;
      c0_c   = '0;
      c1_c   = '0;
      r0     = '0;
      r1     = '0;
      for (int k = 0; k < NBLK; k++) begin
         r0 = blk_add(a[k*BLOCK +: BLOCK], beff[k*BLOCK +: BLOCK], (k == 0) ? ceff : 1'b0);
         r1 = blk_add(a[k*BLOCK +: BLOCK], beff[k*BLOCK +: BLOCK], (k == 0) ? ceff : 1'b1);
         sum0_c[k] = r0[BLOCK-1:0];
         c0_c[k]   = r0[BLOCK];
         sum1_c[k] = r1[BLOCK-1:0];
         c1_c[k]   = r1[BLOCK];
      end
   end

   always_ff @(posedge clk) begin
      if (load_p1) begin
         sum0_p1 <= sum0_c;
         sum1_p1 <= sum1_c;
         c0_p1   <= c0_c;
         c1_p1   <= c1_c;
         sa_p1   <= a[WIDTH-1];
         sb_p1   <= beff[WIDTH-1];
      end
   end

   // Stage 2: left-to-right select chain
   always_comb begin
      sum_c   = '0;
      carry_c = 1'b0;
      for (int k = 0; k < NBLK; k++) begin
         sum_c[k*BLOCK +: BLOCK] = carry_c ? sum1_p1[k] : sum0_p1[k];
         carry_c                 = carry_c ? c1_p1[k] : c0_p1[k];
      end
      ovf_c = (sa_p1 == sb_p1) && (sum_c[WIDTH-1] != sa_p1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (s1_adv) vld_p1 <= in_valid;
         if (s2_adv) vld_p2 <= vld_p1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_p2  <= '0;
         cout_p2 <= 1'b0;
         ovf_p2  <= 1'b0;
      end else if (load_p2) begin
         sum_p2  <= sum_c;
         cout_p2 <= carry_c;
         ovf_p2  <= ovf_c;
      end
   end

   assign out_valid = vld_p2;
   assign sum       = sum_p2;
   assign cout      = cout_p2;
   assign ovf       = ovf_p2;
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed and scoreboarded stream bench for pipelined_csel_adder at 32/4 and 24/8.
module tb_pipelined_csel_adder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready, cin, sub;
   logic [31:0] a, b;
   logic        in_ready, out_valid, cout, ovf;
   logic [31:0] sum;
   logic        in_ready24, out_valid24, cout24, ovf24;
   logic [23:0] sum24;
   int          checks = 0;
   int          failures = 0;
   logic [63:0] q32[$];
   logic [63:0] q24[$];

   always #5 clk = ~clk;

   pipelined_csel_adder #(.WIDTH(32), .BLOCK(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

   pipelined_csel_adder #(.WIDTH(24), .BLOCK(8)) dut24 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready24),
      .a(a[23:0]), .b(b[23:0]), .cin(cin), .sub(sub), .out_valid(out_valid24),
      .out_ready(out_ready), .sum(sum24), .cout(cout24), .ovf(ovf24));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                         input logic c, input logic s);
      logic [63:0] mask, aa, bb, r;
      logic        ov;
      mask = (64'd1 << w) - 64'd1;
      aa   = {32'b0, x} & mask;
      bb   = (s ? ~{32'b0, y} : {32'b0, y}) & mask;
      r    = aa + bb + {63'b0, (s ? 1'b1 : c)};
      ov   = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
      return ({63'b0, ov} << 33) | ({63'b0, r[w]} << 32) | (r & mask);
   endfunction

   function automatic logic [63:0] obs32();
      return {30'b0, ovf, cout, sum};
   endfunction

   function automatic logic [63:0] obs24();
      return {30'b0, ovf24, cout24, 8'b0, sum24};
   endfunction

   // Single beat with out_ready high; called #1 after an edge with the pipe empty.
   task automatic beat(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic c, input logic s, input logic [33:0] exp);
      in_valid = 1'b1; a = x; b = y; cin = c; sub = s; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b0;
      check({tag, "_lat"}, {63'b0, out_valid}, 64'd0);
      @(posedge clk); #1;
      check({tag, "_vld"}, {63'b0, out_valid}, 64'd1);
      check(tag, obs32(), {30'b0, exp});
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #12;
      check("rst_outs", obs32(), 64'd0);
      check("rst_ovld", {63'b0, out_valid}, 64'd0);
      check("rst_irdy", {63'b0, in_ready}, 64'd1);
      rst_n = 1'b1;

      beat("add_ripple", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 34'h1_0000_0000);
      beat("add_blkx",   32'h0000_000F, 32'h1, 1'b0, 1'b0, 34'h0_0000_0010);
      beat("ovf_pos",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 34'h2_8000_0000);
      beat("ovf_neg",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 34'h3_0000_0000);
      beat("sub_neg",    32'h5, 32'h7, 1'b1, 1'b1, 34'h0_FFFF_FFFE);
      beat("sub_ovf",    32'h8000_0000, 32'h1, 1'b0, 1'b1, 34'h3_7FFF_FFFF);
      beat("sub_eq",     32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 34'h1_0000_0000);

      // Backpressure: three back-to-back beats against a stalled consumer
      out_ready = 1'b0; in_valid = 1'b1; a = 1; b = 1; cin = 1'b0; sub = 1'b0;
      #1 check("bp_rdy1", {63'b0, in_ready}, 64'd1);
      @(posedge clk); #1;
      a = 2; b = 2;
      check("bp_rdy2", {63'b0, in_ready}, 64'd1);
      @(posedge clk); #1;
      a = 3; b = 3;
      check("bp_rdy3", {63'b0, in_ready}, 64'd0);
      check("bp_hold0", {31'b0, out_valid, sum}, {31'b0, 1'b1, 32'd2});
      @(posedge clk); #1;
      check("bp_hold1", {31'b0, out_valid, sum}, {31'b0, 1'b1, 32'd2});
      check("bp_rdy4", {63'b0, in_ready}, 64'd0);
      out_ready = 1'b1;
      #1 check("bp_rdy_comb", {63'b0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_out4", {31'b0, out_valid, sum}, {31'b0, 1'b1, 32'd4});
      @(posedge clk); #1;
      check("bp_out6", {31'b0, out_valid, sum}, {31'b0, 1'b1, 32'd6});
      @(posedge clk); #1;
      check("bp_empty", {63'b0, out_valid}, 64'd0);

      // Reset with both stages occupied
      out_ready = 1'b0; in_valid = 1'b1; a = 32'h8000_0000; b = 32'h8000_0000;
      @(posedge clk); #1;
      a = 9; b = 9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mid_full", obs32(), 64'h3_0000_0000);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_outs", obs32(), 64'd0);
      check("mid_rst_ovld", {63'b0, out_valid}, 64'd0);
      check("mid_rst_irdy", {63'b0, in_ready}, 64'd1);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("post_rst_idle", {63'b0, out_valid}, 64'd0);
      beat("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, 34'h0_0000_0007);
      check("post_rst_nostale", {63'b0, out_valid}, 64'd0);

      // Random stream against the arithmetic model at both geometries
      for (int i = 0; i < 1000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         a = $urandom; b = $urandom; cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
         if (i % 50 == 0) a = 32'hFFFF_FFFF;
         #1;
         if (in_valid && in_ready) q32.push_back(model(32, a, b, cin, sub));
         if (in_valid && in_ready24) q24.push_back(model(24, a, b, cin, sub));
         if (out_valid && out_ready) begin
            if (q32.size() == 0) check("s32_spurious", 64'd1, 64'd0);
            else check("s32", obs32(), q32.pop_front());
         end
         if (out_valid24 && out_ready) begin
            if (q24.size() == 0) check("s24_spurious", 64'd1, 64'd0);
            else check("s24", obs24(), q24.pop_front());
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (out_valid) begin
            if (q32.size() == 0) check("d32_spurious", 64'd1, 64'd0);
            else check("d32", obs32(), q32.pop_front());
         end
         if (out_valid24) begin
            if (q24.size() == 0) check("d24_spurious", 64'd1, 64'd0);
            else check("d24", obs24(), q24.pop_front());
         end
         @(posedge clk); #1;
      end
      check("q32_left", 64'(q32.size()), 64'd0);
      check("q24_left", 64'(q24.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipelined_csel_adder.md
# pipelined_csel_adder

Parametrised, two-stage pipelined carry-select adder/subtractor with a valid/ready stream handshake. It is the clocked successor to the fixed 16-bit latch-based carry-select adder. It supports any WIDTH that is a multiple of a uniform BLOCK size, an external carry-in, a subtract mode, a signed-overflow flag, and full backpressure. It sits in the datapath wherever a registered add/sub at one result per cycle is needed.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of BLOCK, WIDTH ≥ 8.
- BLOCK, 4, carry-select block width in bits; BLOCK ≥ 2. NBLK = WIDTH/BLOCK.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a−b.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out. In sub mode, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Effective operands: beff = sub ? ~b : b; ceff = sub ? 1 : cin. The result is {cout, sum} = a + beff + ceff, computed modulo 2^(WIDTH+1).
- ovf = (a[WIDTH-1] == beff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]).
- Stage 1 (S1), registered on acceptance:
  - Block 0 computes its true BLOCK-bit sum and carry using ceff.
  - Each block k ≥ 1 computes two ripple sums in parallel, sum0_k/c0_k (carry-in 0) and sum1_k/c1_k (carry-in 1).
  - S1 also registers the sign bits of a and beff for the ovf calculation.
- Stage 2 (S2): the select chain resolves left to right, with c_k = c_{k-1} ? c1_k : c0_k and sum_k = c_{k-1} ? sum1_k : sum0_k. S2 registers sum, cout and ovf.
- Handshake:
  - A beat transfers on in_valid && in_ready at input, and on out_valid && out_ready at output.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational from the valid registers and out_ready. in_ready has no dependency on in_valid.
  - S1 loads on in_valid && in_ready. S2 loads from S1 when s1_valid && s2_adv. A stage clears its valid flag when it hands off and has no new load.
- out_valid is the S2 valid register. sum, cout and ovf hold stable while out_valid && !out_ready.
- Data registers may load only when the corresponding stage advances. Unaccepted input changes must never alter the output.
- Capacity is 2 beats, with no skid buffer beyond that.
- Reset (asynchronous, any time, including mid-stream):
  - Both valid flags go to 0 and all in-flight beats are discarded.
  - sum=0, cout=0, ovf=0, out_valid=0.
  - in_ready=1 while rst_n is low and after release.
- First acceptance is possible on the first rising edge after rst_n deasserts.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1, provided out_ready stayed high.
- Throughput: 1 beat per cycle sustained while out_ready=1.
- With out_ready=0, at most 2 beats are held. in_ready falls in the cycle both stages are full, and rises combinationally in the same cycle that out_ready rises.
- Simultaneous accept and emit with the pipeline full and out_ready=1: all stages shift and no beat is lost or duplicated.
- Critical path: S1 is one BLOCK-bit ripple. S2 is an NBLK-deep mux chain.

## Test plan
- Add with full carry propagation: a=0xFFFFFFFF, b=0, cin=1, sub=0 → sum=0x00000000, cout=1, ovf=0; out_valid exactly 2 edges after acceptance. Also a=0x0000000F, b=1, cin=0 → sum=0x00000010, which crosses a block boundary.
- Signed overflow: a=0x7FFFFFFF, b=1, cin=0 → sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 → sum=0, cout=1, ovf=1.
- Subtract:
  - a=5, b=7, sub=1, cin=1 (ignored) → sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1, sub=1 → sum=0x7FFFFFFF, cout=1, ovf=1.
  - a=b=0x12345678, sub=1 → sum=0, cout=1.
- Backpressure: out_ready=0 with 3 back-to-back beats (1+1, 2+2, 3+3):
  - First two accepted; in_ready=0 for the third; out sum=2 held stable.
  - Raise out_ready: outputs 2, 4, 6 on consecutive cycles with no loss or duplication.
- Streaming: 1000 random beats with random in_valid and out_ready, at WIDTH=32/BLOCK=4 and WIDTH=24/BLOCK=8 → every output matches the scoreboard model {cout,sum}=a+beff+ceff in order, with ovf correct.
- Reset mid-operation: two beats in flight, pull rst_n low between edges → out_valid, sum, cout and ovf go to 0 immediately and in_ready=1. After release, a new beat 3+4 → sum=7 two edges later, with no stale beats emitted.
